dp_issue_collect: RTL and testbench

//  Issue/collect front end for the registered arithmetic datapaths (ADD/SUB/COMP/MUX2x1/SHL/SHR -> REG).

---
 rtl/hls_pkg.sv | 18 +
 rtl/result_fifo.sv | 48 ++++
 rtl/dp_issue_collect.sv | 99 +++++++++
 tb/tb_dp_issue_collect.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hls_pkg.sv
// Shared constants and width helpers for the HLS datapath front ends.
package hls_pkg;

    localparam int unsigned DATAWIDTH_DEFAULT = 32;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (((value - 1) >> i) != 0) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous result FIFO with extra-MSB pointers for full/empty detection.
module result_fifo
    import hls_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * DATAWIDTH_DEFAULT,
    parameter int unsigned DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_rd;

    assign w_do_rd   = i_rd_en & ~o_empty;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; wrap is natural modulo 2*DEPTH.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage array; contents need no reset since empty gates visibility.
    always_ff @(posedge Clk) begin
        if (i_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/dp_issue_collect.sv
// Issue/collect front end: drives operand triples into a registered datapath
// and returns its z/x results in order, with credit-based flow control.
module dp_issue_collect
    import hls_pkg::*;
#(
    parameter int unsigned DATAWIDTH  = DATAWIDTH_DEFAULT,
    parameter int unsigned DP_LATENCY = 1,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATAWIDTH-1:0] s_a,
    input  logic [DATAWIDTH-1:0] s_b,
    input  logic [DATAWIDTH-1:0] s_c,
    output logic [DATAWIDTH-1:0] dp_a,
    output logic [DATAWIDTH-1:0] dp_b,
    output logic [DATAWIDTH-1:0] dp_c,
    input  logic [DATAWIDTH-1:0] dp_z,
    input  logic [DATAWIDTH-1:0] dp_x,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATAWIDTH-1:0] m_z,
    output logic [DATAWIDTH-1:0] m_x
);

    localparam int unsigned CW = clog2(DEPTH + 1);

    logic [DP_LATENCY:0]     r_vpipe;
    logic [CW-1:0]           r_pending;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_fifo_wr;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [2*DATAWIDTH-1:0]  w_rd_data;

    // Credit check depends only on the pending register, never on m_ready.
    assign s_ready   = (r_pending < CW'(DEPTH));
    assign w_accept  = s_valid & s_ready;
    assign m_valid   = ~w_fifo_empty;
    assign w_pop     = m_valid & m_ready;
    assign w_fifo_wr = r_vpipe[DP_LATENCY];
    assign m_z       = w_rd_data[2*DATAWIDTH-1:DATAWIDTH];
    assign m_x       = w_rd_data[DATAWIDTH-1:0];

    // Operand registers feeding the datapath; hold when nothing is accepted.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            dp_a <= '0;
            dp_b <= '0;
            dp_c <= '0;
        end else if (w_accept) begin
            dp_a <= s_a;
            dp_b <= s_b;
            dp_c <= s_c;
        end
    end

    // Valid pipeline marking when the datapath output belongs to an accepted op.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe <= {r_vpipe[DP_LATENCY-1:0], w_accept};
        end
    end

    // Outstanding-op counter: in-flight plus buffered results.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_pending <= '0;
        end else if (w_accept && !w_pop) begin
            r_pending <= r_pending + CW'(1);
        end else if (w_pop && !w_accept) begin
            r_pending <= r_pending - CW'(1);
        end
    end

    result_fifo #(
        .WIDTH (2 * DATAWIDTH),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data ({dp_z, dp_x}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_empty   (w_fifo_empty),
        .o_full    (w_fifo_full)
    );

    // Credits must make a write into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge Clk) disable iff (!Rst) !(w_fifo_wr && w_fifo_full))
        else $error("result FIFO overflow");

endmodule

// File: tb/tb_dp_issue_collect.sv
// Bench for dp_issue_collect: two instances (latency 1 and latency 3) with stub datapaths,
// a vector table for single ops, a scoreboard for streams, and hand sequences for corners.
module tb_dp_issue_collect;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] s_a, s_b, s_c;

    logic        s_valid0, s_ready0, m_valid0, m_ready0;
    logic [31:0] dp_a0, dp_b0, dp_c0, dp_z0, dp_x0, m_z0, m_x0;
    logic        s_valid1, s_ready1, m_valid1, m_ready1;
    logic [31:0] dp_a1, dp_b1, dp_c1, dp_z1, dp_x1, m_z1, m_x1;
    logic [31:0] p1z [2];
    logic [31:0] p1x [2];

    always #5 Clk = ~Clk;

    dp_issue_collect #(.DATAWIDTH(32), .DP_LATENCY(1), .DEPTH(4)) dut0 (
        .Clk(Clk), .Rst(Rst), .s_valid(s_valid0), .s_ready(s_ready0),
        .s_a(s_a), .s_b(s_b), .s_c(s_c), .dp_a(dp_a0), .dp_b(dp_b0), .dp_c(dp_c0),
        .dp_z(dp_z0), .dp_x(dp_x0), .m_valid(m_valid0), .m_ready(m_ready0),
        .m_z(m_z0), .m_x(m_x0));

    dp_issue_collect #(.DATAWIDTH(32), .DP_LATENCY(3), .DEPTH(4)) dut1 (
        .Clk(Clk), .Rst(Rst), .s_valid(s_valid1), .s_ready(s_ready1),
        .s_a(s_a), .s_b(s_b), .s_c(s_c), .dp_a(dp_a1), .dp_b(dp_b1), .dp_c(dp_c1),
        .dp_z(dp_z1), .dp_x(dp_x1), .m_valid(m_valid1), .m_ready(m_ready1),
        .m_z(m_z1), .m_x(m_x1));

    // Stub datapaths: z = a+b, x = c<<1, registered 1 and 3 times.
    always @(posedge Clk) begin
        dp_z0  <= dp_a0 + dp_b0;
        dp_x0  <= dp_c0 << 1;
        p1z[0] <= dp_a1 + dp_b1;
        p1x[0] <= dp_c1 << 1;
        p1z[1] <= p1z[0];
        p1x[1] <= p1x[0];
        dp_z1  <= p1z[1];
        dp_x1  <= p1x[1];
    end

    typedef struct {
        logic [31:0] a, b, c;
        logic [31:0] exp_z, exp_x;
    } vec_t;

    vec_t        vecs [5];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    int          n_chk = 0, n_err = 0, n_acc = 0, n_pop = 0, n_stall = 0;
    logic        obs_mv, obs_sr;
    logic [31:0] obs_mz, obs_mx;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then drive the next inputs.
    task automatic step(input bit d, input logic sv, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic mr);
        logic        acc, pop;
        logic [31:0] ez, ex;
        logic [63:0] exp;
        @(negedge Clk);
        obs_mv = d ? m_valid1 : m_valid0;
        obs_sr = d ? s_ready1 : s_ready0;
        obs_mz = d ? m_z1 : m_z0;
        obs_mx = d ? m_x1 : m_x0;
        s_a = a; s_b = b; s_c = c;
        s_valid0 = d ? 1'b0 : sv;
        m_ready0 = d ? 1'b0 : mr;
        s_valid1 = d ? sv : 1'b0;
        m_ready1 = d ? mr : 1'b0;
        acc = sv & obs_sr;
        pop = obs_mv & mr;
        if (sv && !obs_sr) n_stall++;
        if (pop) begin
            n_pop++;
            if ((d ? q1.size() : q0.size()) == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL scoreboard: result z=%0h x=%0h with nothing outstanding", obs_mz, obs_mx);
            end else begin
                exp = d ? q1.pop_front() : q0.pop_front();
                chk("result", {obs_mz, obs_mx}, exp);
            end
        end
        if (acc) begin
            n_acc++;
            ez = a + b;
            ex = c << 1;
            if (d) q1.push_back({ez, ex});
            else   q0.push_back({ez, ex});
        end
    endtask

    task automatic idle(input bit d, input logic mr);
        step(d, 1'b0, 32'd0, 32'd0, 32'd0, mr);
    endtask

    task automatic clear_counts();
        n_acc = 0; n_pop = 0; n_stall = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'd5,        32'd3,        32'd7,        32'd8,        32'd14};
        vecs[1] = '{32'hffffffff, 32'd1,        32'h80000000, 32'd0,        32'd0};
        vecs[2] = '{32'h12345678, 32'h11111111, 32'h7fffffff, 32'h23456789, 32'hfffffffe};
        vecs[3] = '{32'd0,        32'd0,        32'd0,        32'd0,        32'd0};
        vecs[4] = '{32'hdeadbeef, 32'd0,        32'd1,        32'hdeadbeef, 32'd2};

        Rst = 1'b0;
        s_a = '0; s_b = '0; s_c = '0;
        s_valid0 = 1'b0; m_ready0 = 1'b0; s_valid1 = 1'b0; m_ready1 = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_m_valid", 64'(m_valid0), 64'd0);
        chk("reset_s_ready", 64'(s_ready0), 64'd1);
        chk("reset_dp_a", 64'(dp_a0), 64'd0);
        chk("reset_m_valid_l3", 64'(m_valid1), 64'd0);
        Rst = 1'b1;

        // Single ops from the table: latency of two edges and exact values.
        foreach (vecs[i]) begin
            step(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].c, 1'b1);
            idle(1'b0, 1'b1);
            chk("single_lat1", 64'(obs_mv), 64'd0);
            idle(1'b0, 1'b1);
            chk("single_lat2", 64'(obs_mv), 64'd0);
            idle(1'b0, 1'b1);
            chk("single_valid", 64'(obs_mv), 64'd1);
            chk("single_z", 64'(obs_mz), 64'(vecs[i].exp_z));
            chk("single_x", 64'(obs_mx), 64'(vecs[i].exp_x));
            idle(1'b0, 1'b1);
            chk("single_done", 64'(obs_mv), 64'd0);
        end

        // Backpressure: only DEPTH ops accepted, credit returns after the first pop.
        clear_counts();
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b1, 32'(i), 32'd0, 32'd0, 1'b0);
            if (i >= 5) chk("bp_s_ready_low", 64'(obs_sr), 64'd0);
        end
        chk("bp_accepted", 64'(n_acc), 64'd4);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b1);
        chk("bp_pop_ready", 64'(obs_sr), 64'd0);
        chk("bp_pop_valid", 64'(obs_mv), 64'd1);
        idle(1'b0, 1'b1);
        chk("bp_ready_back", 64'(obs_sr), 64'd1);
        for (int k = 0; k < 8; k++) idle(1'b0, 1'b1);
        chk("bp_popped", 64'(n_pop), 64'd4);
        chk("bp_drained", 64'(q0.size()), 64'd0);

        // Streaming: never throttled, one result per cycle once the pipe fills.
        clear_counts();
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 32'(i), 32'(i), 32'd0, 1'b1);
            chk("stream_s_ready", 64'(obs_sr), 64'd1);
            if (i >= 3) chk("stream_m_valid", 64'(obs_mv), 64'd1);
        end
        for (int k = 0; k < 6; k++) idle(1'b0, 1'b1);
        chk("stream_popped", 64'(n_pop), 64'd16);
        chk("stream_drained", 64'(q0.size()), 64'd0);

        // Full FIFO with a single-cycle pop.
        clear_counts();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'(100 + i), 32'd1, 32'(i), 1'b0);
        for (int k = 0; k < 3; k++) idle(1'b0, 1'b0);
        step(1'b0, 1'b1, 32'd999, 32'd1, 32'd0, 1'b1);
        chk("full_s_ready", 64'(obs_sr), 64'd0);
        chk("full_m_valid", 64'(obs_mv), 64'd1);
        idle(1'b0, 1'b0);
        chk("full_ready_after_pop", 64'(obs_sr), 64'd1);
        chk("full_one_pop", 64'(n_pop), 64'd1);
        chk("full_remaining", 64'(q0.size()), 64'd3);
        chk("full_no_extra_accept", 64'(n_acc), 64'd4);
        for (int k = 0; k < 6; k++) idle(1'b0, 1'b1);
        chk("full_drained", 64'(q0.size()), 64'd0);

        // Reset mid-burst: two results buffered, two in flight, all discarded.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'(50 + i), 32'd2, 32'd3, 1'b0);
        idle(1'b0, 1'b0);
        chk("rst_pre_valid", 64'(obs_mv), 64'd1);
        #1;
        Rst = 1'b0;
        #1;
        chk("rst_m_valid", 64'(m_valid0), 64'd0);
        chk("rst_dp_a", 64'(dp_a0), 64'd0);
        chk("rst_dp_c", 64'(dp_c0), 64'd0);
        q0.delete();
        @(negedge Clk);
        Rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            idle(1'b0, 1'b1);
            chk("rst_no_stale", 64'(obs_mv), 64'd0);
            chk("rst_s_ready", 64'(obs_sr), 64'd1);
        end

        // Latency-3 instance under sustained traffic: throttled, nothing lost.
        clear_counts();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 32'(i), 32'(3 * i), 32'(i + 100), 1'b1);
        end
        for (int k = 0; k < 12; k++) idle(1'b1, 1'b1);
        chk("l3_throttled", 64'(n_stall > 0), 64'd1);
        chk("l3_all_returned", 64'(n_pop), 64'(n_acc));
        chk("l3_drained", 64'(q1.size()), 64'd0);
        chk("l3_idle", 64'(obs_mv), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
